// File: rtl/comb_pingpong_ctrl_if.sv
// Handshake bundle between the combination producer, the fit consumer and the
// ping-pong bank controller.
interface comb_pingpong_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              wr_valid;
  logic              wr_last;
  logic              wr_ready;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_valid;
  logic              rd_en;
  logic              rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_last;
  logic [ADDR_W:0]   rd_count;
  logic [15:0]       ev_count;
  logic              err_overflow;

  modport slave (
    input  wr_valid, wr_last, rd_en,
    output wr_ready, wr_en, wr_bank, wr_addr,
    output rd_valid, rd_bank, rd_addr, rd_last, rd_count,
    output ev_count, err_overflow
  );

  modport master (
    output wr_valid, wr_last, rd_en,
    input  wr_ready, wr_en, wr_bank, wr_addr,
    input  rd_valid, rd_bank, rd_addr, rd_last, rd_count,
    input  ev_count, err_overflow
  );
endinterface

// File: rtl/comb_pingpong_ctrl.sv
// Two-bank ping-pong controller: the writer fills one bank while the reader
// drains the other; banks are handed over whole events at a time.
module comb_pingpong_ctrl #(
  parameter int ADDR_W = 7
) (
  input logic                  clock,
  input logic                  reset_n,
  comb_pingpong_ctrl_if.slave  bus
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_st_e;

  bank_st_e          st_q   [2];
  bank_st_e          st_d   [2];
  logic [CW-1:0]     cnt_q  [2];
  logic [CW-1:0]     cnt_d  [2];
  logic              wsel_q, wsel_d;
  logic              rsel_q, rsel_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic [15:0]       ev_q, ev_d;
  logic              err_q, err_d;

  logic wr_ready, wr_en, wr_close;
  logic rd_valid, rd_last, rd_fire;

  always_comb begin
    wr_ready = (st_q[wsel_q] != BANK_FULL);
    wr_en    = bus.wr_valid & wr_ready;
    wr_close = wr_en & (bus.wr_last | (wcnt_q == ADDR_MAX));
    rd_valid = (st_q[rsel_q] == BANK_FULL);
    // Gate the compare so an unwritten count register never leaks into rd_last.
    rd_last  = rd_valid & ({1'b0, rcnt_q} == (cnt_q[rsel_q] - CW'(1)));
    rd_fire  = bus.rd_en & rd_valid;
  end

  always_comb begin
    st_d[0] = st_q[0];
    st_d[1] = st_q[1];
    cnt_d[0] = cnt_q[0];
    cnt_d[1] = cnt_q[1];
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    ev_d    = ev_q;
    err_d   = err_q;

    if (wr_en) begin
      st_d[wsel_q] = BANK_FILLING;
      wcnt_d       = wcnt_q + ADDR_W'(1);
      if (wr_close) begin
        cnt_d[wsel_q] = {1'b0, wcnt_q} + CW'(1);
        st_d[wsel_q]  = BANK_FULL;
        wsel_d        = ~wsel_q;
        wcnt_d        = '0;
        ev_d          = ev_q + 16'd1;
        // Depth ran out before the producer marked the end of the event.
        if (!bus.wr_last) err_d = 1'b1;
      end
    end

    // The read bank is FULL and the write bank is not, so these never alias.
    if (rd_fire) begin
      rcnt_d = rcnt_q + ADDR_W'(1);
      if (rd_last) begin
        st_d[rsel_q] = BANK_EMPTY;
        rsel_d       = ~rsel_q;
        rcnt_d       = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q[0] <= BANK_EMPTY;
      st_q[1] <= BANK_EMPTY;
      wsel_q  <= 1'b0;
      rsel_q  <= 1'b0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      ev_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      ev_q    <= ev_d;
      err_q   <= err_d;
    end
  end

  // Event lengths are only observed while their bank is FULL.
  always_ff @(posedge clock) begin
    cnt_q[0] <= cnt_d[0];
    cnt_q[1] <= cnt_d[1];
  end

  assign bus.wr_ready     = wr_ready;
  assign bus.wr_en        = wr_en;
  assign bus.wr_bank      = wsel_q;
  assign bus.wr_addr      = wcnt_q;
  assign bus.rd_valid     = rd_valid;
  assign bus.rd_bank      = rsel_q;
  assign bus.rd_addr      = rcnt_q;
  assign bus.rd_last      = rd_last;
  assign bus.rd_count     = rd_valid ? cnt_q[rsel_q] : '0;
  assign bus.ev_count     = ev_q;
  assign bus.err_overflow = err_q;

endmodule

// File: tb/tb_comb_pingpong_ctrl.sv
// Directed bench for comb_pingpong_ctrl (ADDR_W=3): vector table for the
// single-event and stall flows, hand sequences for the multi-cycle corners.
module tb_comb_pingpong_ctrl;

  localparam int AW = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clock = ~clock;

  comb_pingpong_ctrl_if #(.ADDR_W(AW)) bus ();

  comb_pingpong_ctrl #(.ADDR_W(AW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic rst;
    logic wv, wl, re;
    logic wr_ready, wr_en, wb;
    int   wa;
    logic rv, rb;
    int   ra;
    logic rl;
    int   rc;
    int   ev;
    logic err;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rst, input logic wv, input logic wl, input logic re,
                     input logic wr_ready, input logic wr_en, input logic wb, input int wa,
                     input logic rv, input logic rb, input int ra, input logic rl, input int rc,
                     input int ev, input logic err);
    vec_t v;
    v.rst = rst; v.wv = wv; v.wl = wl; v.re = re;
    v.wr_ready = wr_ready; v.wr_en = wr_en; v.wb = wb; v.wa = wa;
    v.rv = rv; v.rb = rb; v.ra = ra; v.rl = rl; v.rc = rc;
    v.ev = ev; v.err = err;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wv, input logic wl, input logic re);
    bus.wr_valid = wv;
    bus.wr_last  = wl;
    bus.rd_en    = re;
  endtask

  task automatic do_reset();
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic apply_row(input int idx, input vec_t v);
    string p;
    if (v.rst) do_reset();
    @(negedge clock);
    drive(v.wv, v.wl, v.re);
    #1;
    p = $sformatf("row%0d_", idx);
    chk({p, "wr_ready"}, 32'(bus.wr_ready), 32'(v.wr_ready));
    chk({p, "wr_en"},    32'(bus.wr_en),    32'(v.wr_en));
    chk({p, "wr_bank"},  32'(bus.wr_bank),  32'(v.wb));
    chk({p, "wr_addr"},  32'(bus.wr_addr),  32'(v.wa));
    chk({p, "rd_valid"}, 32'(bus.rd_valid), 32'(v.rv));
    chk({p, "rd_bank"},  32'(bus.rd_bank),  32'(v.rb));
    chk({p, "rd_addr"},  32'(bus.rd_addr),  32'(v.ra));
    chk({p, "rd_last"},  32'(bus.rd_last),  32'(v.rl));
    chk({p, "rd_count"}, 32'(bus.rd_count), 32'(v.rc));
    chk({p, "ev_count"}, 32'(bus.ev_count), 32'(v.ev));
    chk({p, "err"},      32'(bus.err_overflow), 32'(v.err));
  endtask

  initial begin
    logic [7:0] mem [2][8];
    int q[$];
    int d;
    int nrd;
    int expd;

    drive(1'b0, 1'b0, 1'b0);

    // Single 5-word event, read back, then a stray wr_last without wr_valid.
    add(1,1,0,0, 1,1,0,0, 0,0,0,0,0, 0,0);
    for (int i = 1; i < 4; i++) add(0,1,0,0, 1,1,0,i, 0,0,0,0,0, 0,0);
    add(0,1,1,0, 1,1,0,4, 0,0,0,0,0, 0,0);
    for (int i = 0; i < 4; i++) add(0,0,0,1, 1,0,1,0, 1,0,i,0,5, 1,0);
    add(0,0,0,1, 1,0,1,0, 1,0,4,1,5, 1,0);
    add(0,0,0,0, 1,0,1,0, 0,1,0,0,0, 1,0);
    add(0,0,1,0, 1,0,1,0, 0,1,0,0,0, 1,0);
    add(0,0,0,0, 1,0,1,0, 0,1,0,0,0, 1,0);
    // Stall: two 3-word events fill both banks, third event waits for a drain.
    add(1,1,0,0, 1,1,0,0, 0,0,0,0,0, 0,0);
    add(0,1,0,0, 1,1,0,1, 0,0,0,0,0, 0,0);
    add(0,1,1,0, 1,1,0,2, 0,0,0,0,0, 0,0);
    add(0,1,0,0, 1,1,1,0, 1,0,0,0,3, 1,0);
    add(0,1,0,0, 1,1,1,1, 1,0,0,0,3, 1,0);
    add(0,1,1,0, 1,1,1,2, 1,0,0,0,3, 1,0);
    add(0,1,0,0, 0,0,0,0, 1,0,0,0,3, 2,0);
    add(0,1,0,1, 0,0,0,0, 1,0,0,0,3, 2,0);
    add(0,1,0,0, 0,0,0,0, 1,0,1,0,3, 2,0);
    add(0,1,0,1, 0,0,0,0, 1,0,1,0,3, 2,0);
    add(0,1,0,1, 0,0,0,0, 1,0,2,1,3, 2,0);
    add(0,1,0,0, 1,1,0,0, 1,1,0,0,3, 2,0);
    add(0,1,0,0, 1,1,0,1, 1,1,0,0,3, 2,0);
    add(0,1,1,0, 1,1,0,2, 1,1,0,0,3, 2,0);
    add(0,0,0,0, 0,0,1,0, 1,1,0,0,3, 3,0);

    for (int i = 0; i < vt.size(); i++) apply_row(i, vt[i]);

    // Overflow: 10-word event into 8-word banks.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      drive(1'b1, (i == 9), 1'b0);
      #1;
      chk("ovf_wr_ready", 32'(bus.wr_ready), 32'd1);
      chk("ovf_wr_bank", 32'(bus.wr_bank), (i < 8) ? 32'd0 : 32'd1);
      chk("ovf_wr_addr", 32'(bus.wr_addr), (i < 8) ? 32'(i) : 32'(i - 8));
      if (i == 8) begin
        chk("ovf_err_set", 32'(bus.err_overflow), 32'd1);
        chk("ovf_cnt0", 32'(bus.rd_count), 32'd8);
      end
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("ovf_stall", 32'(bus.wr_ready), 32'd0);
    chk("ovf_ev", 32'(bus.ev_count), 32'd2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      drive(1'b0, 1'b0, 1'b1);
      #1;
      chk("ovf_rd_addr0", 32'(bus.rd_addr), 32'(i));
      chk("ovf_rd_last0", 32'(bus.rd_last), (i == 7) ? 32'd1 : 32'd0);
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("ovf_rd_bank1", 32'(bus.rd_bank), 32'd1);
    chk("ovf_cnt1", 32'(bus.rd_count), 32'd2);
    chk("ovf_err_sticky", 32'(bus.err_overflow), 32'd1);
    chk("ovf_release", 32'(bus.wr_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      drive(1'b0, 1'b0, 1'b1);
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("ovf_err_after_drain", 32'(bus.err_overflow), 32'd1);
    do_reset();
    #1;
    chk("ovf_err_cleared", 32'(bus.err_overflow), 32'd0);

    // Concurrency: back-to-back 4-word events with the reader always pulling.
    do_reset();
    d = 0;
    nrd = 0;
    q.delete();
    for (int cyc = 0; cyc < 32; cyc++) begin
      @(negedge clock);
      drive((cyc < 24), ((cyc % 4) == 3), 1'b1);
      #1;
      if (cyc < 24) begin
        chk("cc_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("cc_wr_bank", 32'(bus.wr_bank), 32'((cyc / 4) % 2));
      end
      chk("cc_ev", 32'(bus.ev_count), (cyc / 4 > 6) ? 32'd6 : 32'(cyc / 4));
      if (bus.wr_en) begin
        mem[bus.wr_bank][bus.wr_addr] = 8'(d + 8'h40);
        q.push_back(d + 8'h40);
        d++;
      end
      if (bus.rd_valid) begin
        chk("cc_rd_bank", 32'(bus.rd_bank), 32'((nrd / 4) % 2));
        if (q.size() == 0) begin
          chk("cc_rd_underflow", 32'd1, 32'd0);
        end else begin
          expd = q.pop_front();
          chk("cc_rd_data", 32'(mem[bus.rd_bank][bus.rd_addr]), 32'(expd));
        end
        nrd++;
      end
    end
    chk("cc_read_words", 32'(nrd), 32'd24);
    chk("cc_queue_empty", 32'(q.size()), 32'd0);

    // Asynchronous reset in the middle of an event.
    do_reset();
    @(negedge clock); drive(1'b1, 1'b1, 1'b0);
    @(negedge clock); drive(1'b1, 1'b0, 1'b0);
    @(negedge clock); drive(1'b1, 1'b0, 1'b0);
    @(negedge clock); drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("mr_pre_bank", 32'(bus.wr_bank), 32'd1);
    chk("mr_pre_addr", 32'(bus.wr_addr), 32'd2);
    chk("mr_pre_ev", 32'(bus.ev_count), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("mr_wr_bank", 32'(bus.wr_bank), 32'd0);
    chk("mr_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("mr_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("mr_rd_bank", 32'(bus.rd_bank), 32'd0);
    chk("mr_rd_count", 32'(bus.rd_count), 32'd0);
    chk("mr_rd_last", 32'(bus.rd_last), 32'd0);
    chk("mr_ev", 32'(bus.ev_count), 32'd0);
    chk("mr_err", 32'(bus.err_overflow), 32'd0);
    bus.wr_valid = 1'b1;
    #1;
    chk("mr_wr_en_follows", 32'(bus.wr_en), 32'd1);
    bus.wr_valid = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      drive(1'b1, (i == 3), 1'b0);
      #1;
      chk("mr_post_bank", 32'(bus.wr_bank), 32'd0);
      chk("mr_post_addr", 32'(bus.wr_addr), 32'(i));
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("mr_post_count", 32'(bus.rd_count), 32'd4);

    // 1-word events with continuous reads.
    do_reset();
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clock);
      drive(1'b1, 1'b1, 1'b1);
      #1;
      chk("ow_wr_ready", 32'(bus.wr_ready), 32'd1);
      chk("ow_wr_bank", 32'(bus.wr_bank), 32'(cyc % 2));
      if (cyc >= 1) begin
        chk("ow_rd_valid", 32'(bus.rd_valid), 32'd1);
        chk("ow_rd_last", 32'(bus.rd_last), 32'(bus.rd_valid));
        chk("ow_rd_count", 32'(bus.rd_count), 32'd1);
        chk("ow_rd_bank", 32'(bus.rd_bank), 32'((cyc - 1) % 2));
      end
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
